// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register IDs and status codes.
// Used by the decode/writeback block and its register file.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] IRRMOVQ = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam logic [3:0] RRSP  = 4'd4;
  localparam logic [3:0] RNONE = 4'd15;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

endpackage

// File: rtl/regfile15x64.sv
// 15-entry register file: two combinational read ports, two write ports.
// When both write ports target the same register, the M port wins.
module regfile15x64
  import y86_pkg::*;
#(
  parameter int NREGS = 15,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   srca,
  input  logic [3:0]   srcb,
  output logic [W-1:0] vala,
  output logic [W-1:0] valb,
  input  logic         we,
  input  logic [3:0]   dste,
  input  logic [W-1:0] vale,
  input  logic [3:0]   dstm,
  input  logic [W-1:0] valm
);

  logic [W-1:0] regs [NREGS];

  // RNONE never matches an entry, so it reads as zero and writes are dropped.
  always_comb begin
    vala = '0;
    valb = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (srca == 4'(i)) vala = regs[i];
      if (srcb == 4'(i)) valb = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NREGS; i++) begin
        if (dstm == 4'(i))      regs[i] <= valm;
        else if (dste == 4'(i)) regs[i] <= vale;
      end
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/writeback: operand selection, register commit, sticky status.
// Define DECODE_WRITEBACK_RETIRE_CNT_EN to build the 64-bit retired-instruction counter.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int NREGS = 15,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   icode,
  input  logic [3:0]   rA,
  input  logic [3:0]   rB,
  input  logic         cnd,
  input  logic [W-1:0] valE,
  input  logic [W-1:0] valM,
  input  logic [2:0]   stat_in,
  output logic [W-1:0] valA,
  output logic [W-1:0] valB,
  output logic [2:0]   stat,
  output logic         halted,
  output logic [63:0]  retired
);

  logic [3:0] srca, srcb, dste, dstm;
  logic       we;

  // Codes outside the defined set are reported as an invalid instruction.
  function automatic logic [2:0] norm_stat(input logic [2:0] s);
    case (s)
      SAOK, SHLT, SADR, SINS: norm_stat = s;
      default:                norm_stat = SINS;
    endcase
  endfunction

  always_comb begin
    case (icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: srca = rA;
      IRET, IPOPQ:                    srca = RRSP;
      default:                        srca = RNONE;
    endcase
  end

  always_comb begin
    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ:     srcb = rB;
      ICALL, IRET, IPUSHQ, IPOPQ: srcb = RRSP;
      default:                    srcb = RNONE;
    endcase
  end

  always_comb begin
    case (icode)
      IRRMOVQ:                    dste = cnd ? rB : RNONE;
      IIRMOVQ, IOPQ:              dste = rB;
      ICALL, IRET, IPUSHQ, IPOPQ: dste = RRSP;
      default:                    dste = RNONE;
    endcase
  end

  always_comb begin
    case (icode)
      IMRMOVQ, IPOPQ: dstm = rA;
      default:        dstm = RNONE;
    endcase
  end

  // Only a healthy instruction on a healthy machine commits.
  assign we = (stat == SAOK) && (stat_in == SAOK);

  regfile15x64 #(
    .NREGS(NREGS),
    .W    (W)
  ) u_rf (
    .clk  (clk),
    .reset(reset),
    .srca (srca),
    .srcb (srcb),
    .vala (valA),
    .valb (valB),
    .we   (we),
    .dste (dste),
    .vale (valE),
    .dstm (dstm),
    .valm (valM)
  );

  // Status captures the first fault and then holds until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat <= SAOK;
    end else if ((stat == SAOK) && (stat_in != SAOK)) begin
      stat <= norm_stat(stat_in);
    end
  end

  assign halted = (stat != SAOK);

`ifdef DECODE_WRITEBACK_RETIRE_CNT_EN
  logic [63:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (we) begin
      retired_q <= retired_q + 64'd1;
    end
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: doc/decode_writeback.md
# decode_writeback

SEQ-stage register file block, covering decode (source-register selection and operand read) and writeback (destination selection and update) for the Y86-64 single-cycle core. It sits directly downstream of the memory stage: it consumes valE from execute and valM from memory, and commits them to the 15-entry register file at the clock edge. It also holds the architectural processor status, which freezes all state once a non-AOK status retires.

## Interface
Parameters:
- NREGS, 15: architectural registers, IDs 0..14; ID 15 (RNONE) means no register.
- W, 64: data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- icode  in  4  current instruction code.
- rA, rB  in  4  register specifiers from fetch.
- cnd  in  1  condition result from execute (used for cmovXX).
- valE  in  W  ALU result.
- valM  in  W  memory read data.
- stat_in  in  3  status of the current instruction: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- valA, valB  out  W  combinational operand reads.
- stat  out  3  latched processor status.
- halted  out  1  high when stat != AOK.
- retired  out  64  retired-instruction count.

## Operation
Source selection:
- srcA = rA for icode 2, 4, 6, 10.
- srcA = 4 (%rsp) for icode 9, 11.
- srcA = 15 otherwise.
- srcB = rB for icode 4, 5, 6.
- srcB = 4 for icode 8, 9, 10, 11.
- srcB = 15 otherwise.

Destination selection:
- dstE = rB for icode 2 only when cnd = 1.
- dstE = rB for icode 3 and 6.
- dstE = 4 for icode 8, 9, 10, 11.
- dstE = 15 otherwise.
- dstM = rA for icode 5 and 11.
- dstM = 15 otherwise.

Reads:
- valA = reg[srcA] and valB = reg[srcB].
- A source of 15 reads 0.

Writes:
- Write enable we = (stat == AOK) && (stat_in == AOK).
- When we is high, reg[dstE] <= valE and reg[dstM] <= valM.
- Writes to ID 15 are discarded.
- If dstE == dstM (popq %rsp), the valM write wins.

Status:
- When stat == AOK and stat_in != AOK, stat <= stat_in. The faulting instruction does not write registers.
- Once stat != AOK, the status is sticky until reset. Registers, stat and retired are all frozen.
- stat_in values outside 1..4 are treated as INS (4).

Retire counter:
- retired increments by 1 on each edge where we is high.
- A HLT instruction is not counted.
- The counter wraps modulo 2^64.

## Timing
- Reads are combinational, with zero latency. A read in the same cycle as a write to the same register returns the pre-edge value; there is no bypass.
- Writes and the status update take effect at the rising edge; the new value is visible on valA/valB in the next cycle.
- Reset is synchronous: all registers become 0, stat becomes AOK (1), halted becomes 0 and retired becomes 0.
- Reset has priority over any write or status capture at the same edge.
- Reset asserted mid-program clears a halted state.

## Configuration
- Macro: DECODE_WRITEBACK_RETIRE_CNT_EN.
- Defined: the 64-bit retired counter is implemented as described above.
- Undefined: no counter flop exists, and retired is tied to 0.

## Structure
Shared package y86_pkg contains:
- icode constants: IHALT 0, INOP 1, IRRMOVQ 2, IIRMOVQ 3, IRMMOVQ 4, IMRMOVQ 5, IOPQ 6, IJXX 7, ICALL 8, IRET 9, IPUSHQ 10, IPOPQ 11.
- Register IDs: RRSP 4, RNONE 15.
- Status codes: SAOK 1, SHLT 2, SADR 3, SINS 4.

Sub-module regfile15x64 holds the register array, with two combinational read ports and two write ports using M-over-E priority. decode_writeback instantiates it and contains the select, status and counter logic.

## Test plan
- **Reset and read:** assert reset for 1 cycle, then icode 6, rA 0, rB 1 → valA = 0, valB = 0, stat = 1, retired = 0.
- **irmovq:** icode 3, rB 2, valE 0x1234 for one edge. Next cycle, icode 6, rA 2 → valA = 0x1234 and retired = 1.
- **popq %rsp:** icode 11, rA 4, valE 0x100, valM 0xBEEF → %rsp = 0xBEEF, not 0x100.
- **cmovXX not taken:** icode 2, rB 3, cnd 0, valE 0x55 → %rbx unchanged (0), but retired still increments.
- **Halt freeze:** stat_in 2 on icode 0 → stat = 2 and halted = 1. Subsequent irmovq to %rcx with stat_in 1 leaves %rcx = 0 and retired unchanged. Reset then restores stat = 1.
- **Reset priority:** reset with a simultaneous irmovq of 0x99 to %rax → %rax = 0 after the edge.
